cobro_monedas: RTL and testbench

// Payment-side counterpart of the coffee-machine controller. Latches the 4-bit price code, accepts coins
// and accumulates their value. Returns the one-cycle PAGO_RECIBIDO pulse to the controller once paid.

---
 rtl/maquina_pkg.sv | 66 ++++++
 rtl/selector_vuelto.sv | 30 +++
 rtl/cobro_monedas.sv | 172 +++++++++++++++++
 tb/tb_cobro_monedas.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maquina_pkg.sv
// Shared definitions for the coffee machine: coin and price codes, their values in 50-colon units,
// and the payment-side state encoding.
package maquina_pkg;

  localparam int unsigned ANCHO_UNID = 7;

  typedef enum logic [1:0] {
    MONEDA_50   = 2'b00,
    MONEDA_100  = 2'b01,
    MONEDA_500  = 2'b10,
    MONEDA_1000 = 2'b11
  } moneda_e;

  // Price codes as shown by the controller while it waits for payment.
  typedef enum logic [3:0] {
    PRECIO_500  = 4'b0001,
    PRECIO_1000 = 4'b0010,
    PRECIO_1500 = 4'b0011,
    PRECIO_750  = 4'b0100,
    PRECIO_1250 = 4'b0101,
    PRECIO_1750 = 4'b0110,
    PRECIO_2000 = 4'b0111,
    PRECIO_2250 = 4'b1000
  } precio_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COBRANDO = 2'd1,
    PAGADO   = 2'd2,
    ENTREGA  = 2'd3
  } estado_e;

  localparam logic [ANCHO_UNID-1:0] UNID_50   = 7'd1;
  localparam logic [ANCHO_UNID-1:0] UNID_100  = 7'd2;
  localparam logic [ANCHO_UNID-1:0] UNID_500  = 7'd10;
  localparam logic [ANCHO_UNID-1:0] UNID_1000 = 7'd20;

  function automatic logic [ANCHO_UNID-1:0] valor_moneda(input logic [1:0] codigo);
    logic [ANCHO_UNID-1:0] valor;
    case (codigo)
      MONEDA_50:   valor = UNID_50;
      MONEDA_100:  valor = UNID_100;
      MONEDA_500:  valor = UNID_500;
      default:     valor = UNID_1000;
    endcase
    return valor;
  endfunction

  // Unknown codes map to 0 units, which the collector treats as an invalid price.
  function automatic logic [ANCHO_UNID-1:0] precio_unidades(input logic [3:0] codigo);
    logic [ANCHO_UNID-1:0] unidades;
    case (codigo)
      PRECIO_500:  unidades = 7'd10;
      PRECIO_1000: unidades = 7'd20;
      PRECIO_1500: unidades = 7'd30;
      PRECIO_750:  unidades = 7'd15;
      PRECIO_1250: unidades = 7'd25;
      PRECIO_1750: unidades = 7'd35;
      PRECIO_2000: unidades = 7'd40;
      PRECIO_2250: unidades = 7'd45;
      default:     unidades = 7'd0;
    endcase
    return unidades;
  endfunction

endpackage

// File: rtl/selector_vuelto.sv
// Greedy coin picker: largest coin not exceeding the pending amount, or nothing when it is zero.
module selector_vuelto
  import maquina_pkg::*;
#(
  parameter int unsigned ANCHO_MONTO = 7
) (
  input  logic [ANCHO_MONTO-1:0] resto_i,
  output logic [1:0]             moneda_o,
  output logic [ANCHO_MONTO-1:0] valor_o
);

  always_comb begin
    moneda_o = MONEDA_50;
    valor_o  = '0;
    if (resto_i >= ANCHO_MONTO'(UNID_1000)) begin
      moneda_o = MONEDA_1000;
      valor_o  = ANCHO_MONTO'(UNID_1000);
    end else if (resto_i >= ANCHO_MONTO'(UNID_500)) begin
      moneda_o = MONEDA_500;
      valor_o  = ANCHO_MONTO'(UNID_500);
    end else if (resto_i >= ANCHO_MONTO'(UNID_100)) begin
      moneda_o = MONEDA_100;
      valor_o  = ANCHO_MONTO'(UNID_100);
    end else if (resto_i != '0) begin
      moneda_o = MONEDA_50;
      valor_o  = ANCHO_MONTO'(UNID_50);
    end
  end

endmodule

// File: rtl/cobro_monedas.sv
// Payment collector: latches the price, accumulates coins, signals payment to the controller and
// hands out change or a full refund one coin at a time over a valid/ack handshake.
module cobro_monedas
  import maquina_pkg::*;
#(
  parameter int unsigned ANCHO_MONTO = 7,
  parameter int unsigned ESPERA_ACK  = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             precio_in,
  input  logic                   precio_valido,
  input  logic [1:0]             moneda_in,
  input  logic                   moneda_in_valid,
  input  logic                   cancelar,
  output logic                   pago_recibido,
  output logic [ANCHO_MONTO-1:0] monto_acumulado,
  output logic [1:0]             moneda_out,
  output logic                   moneda_out_valid,
  input  logic                   moneda_out_ack,
  output logic                   es_devolucion,
  output logic                   moneda_rechazada,
  output logic                   precio_invalido,
  output logic                   ocupado
);

  // Reserved ack-timeout hook; this revision has no logic behind it.
  if (ESPERA_ACK != 0) begin : g_espera_ack_reservada
  end

  estado_e                state_q, state_d;
  logic [ANCHO_MONTO-1:0] precio_q, precio_d;
  logic [ANCHO_MONTO-1:0] acum_q, acum_d;
  logic [ANCHO_MONTO-1:0] resto_q, resto_d;
  logic [ANCHO_MONTO-1:0] monto_q, monto_d;
  logic [1:0]             moneda_out_q, moneda_out_d;
  logic                   precio_valido_prev_q;
  logic                   pago_q, pago_d;
  logic                   valid_q, valid_d;
  logic                   es_dev_q, es_dev_d;
  logic                   rechazada_q, rechazada_d;
  logic                   invalido_q, invalido_d;
  logic                   ocupado_q, ocupado_d;

  logic [ANCHO_MONTO-1:0] valor_in;
  logic [ANCHO_MONTO-1:0] suma;
  logic [ANCHO_MONTO-1:0] precio_nuevo;
  logic [1:0]             codigo_sel;
  logic [ANCHO_MONTO-1:0] valor_sel;

  selector_vuelto #(.ANCHO_MONTO(ANCHO_MONTO)) u_selector (
    .resto_i  (resto_q),
    .moneda_o (codigo_sel),
    .valor_o  (valor_sel)
  );

  assign valor_in     = moneda_in_valid ? ANCHO_MONTO'(valor_moneda(moneda_in)) : '0;
  assign suma         = acum_q + valor_in;
  assign precio_nuevo = ANCHO_MONTO'(precio_unidades(precio_in));

  always_comb begin
    state_d      = state_q;
    precio_d     = precio_q;
    acum_d       = acum_q;
    resto_d      = resto_q;
    moneda_out_d = moneda_out_q;
    valid_d      = valid_q;
    es_dev_d     = es_dev_q;
    pago_d       = 1'b0;
    invalido_d   = 1'b0;
    rechazada_d  = moneda_in_valid && (state_q != COBRANDO);

    case (state_q)
      IDLE: begin
        if (precio_valido && !precio_valido_prev_q) begin
          if (precio_nuevo != '0) begin
            precio_d = precio_nuevo;
            acum_d   = '0;
            state_d  = COBRANDO;
          end else begin
            invalido_d = 1'b1;
          end
        end
      end
      COBRANDO: begin
        // Abandoning the sale wins over completing it; a coin in the same cycle is refunded too.
        if (cancelar || !precio_valido) begin
          resto_d = suma;
          acum_d  = '0;
          if (suma != '0) begin
            es_dev_d = 1'b1;
            state_d  = ENTREGA;
          end else begin
            state_d = IDLE;
          end
        end else if (suma >= precio_q) begin
          resto_d = suma - precio_q;
          acum_d  = '0;
          pago_d  = 1'b1;
          state_d = PAGADO;
        end else begin
          acum_d = suma;
        end
      end
      PAGADO: begin
        state_d = (resto_q != '0) ? ENTREGA : IDLE;
      end
      ENTREGA: begin
        // resto_q is frozen while a coin is offered, so the selector still names that coin at ack.
        if (valid_q) begin
          if (moneda_out_ack) begin
            resto_d      = resto_q - valor_sel;
            valid_d      = 1'b0;
            moneda_out_d = MONEDA_50;
          end
        end else if (resto_q == '0) begin
          es_dev_d = 1'b0;
          state_d  = IDLE;
        end else begin
          valid_d      = 1'b1;
          moneda_out_d = codigo_sel;
        end
      end
      default: state_d = IDLE;
    endcase

    monto_d   = (state_d == COBRANDO) ? acum_d : '0;
    ocupado_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q              <= IDLE;
      precio_q             <= '0;
      acum_q               <= '0;
      resto_q              <= '0;
      monto_q              <= '0;
      moneda_out_q         <= '0;
      precio_valido_prev_q <= 1'b0;
      pago_q               <= 1'b0;
      valid_q              <= 1'b0;
      es_dev_q             <= 1'b0;
      rechazada_q          <= 1'b0;
      invalido_q           <= 1'b0;
      ocupado_q            <= 1'b0;
    end else begin
      state_q              <= state_d;
      precio_q             <= precio_d;
      acum_q               <= acum_d;
      resto_q              <= resto_d;
      monto_q              <= monto_d;
      moneda_out_q         <= moneda_out_d;
      precio_valido_prev_q <= precio_valido;
      pago_q               <= pago_d;
      valid_q              <= valid_d;
      es_dev_q             <= es_dev_d;
      rechazada_q          <= rechazada_d;
      invalido_q           <= invalido_d;
      ocupado_q            <= ocupado_d;
    end
  end

  assign pago_recibido    = pago_q;
  assign monto_acumulado  = monto_q;
  assign moneda_out       = moneda_out_q;
  assign moneda_out_valid = valid_q;
  assign es_devolucion    = es_dev_q;
  assign moneda_rechazada = rechazada_q;
  assign precio_invalido  = invalido_q;
  assign ocupado          = ocupado_q;

endmodule

// File: tb/tb_cobro_monedas.sv
// Directed bench for cobro_monedas: exact payment, change, accumulation, cancel/refund,
// price withdrawal, rejected coins, invalid price and reset during dispensing.
module tb_cobro_monedas;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] precio_in;
  logic       precio_valido;
  logic [1:0] moneda_in;
  logic       moneda_in_valid;
  logic       cancelar;
  logic       pago_recibido;
  logic [6:0] monto_acumulado;
  logic [1:0] moneda_out;
  logic       moneda_out_valid;
  logic       moneda_out_ack;
  logic       es_devolucion;
  logic       moneda_rechazada;
  logic       precio_invalido;
  logic       ocupado;

  int compared   = 0;
  int mismatched = 0;

  cobro_monedas #(.ANCHO_MONTO(7), .ESPERA_ACK(0)) dut (
    .clk              (clk),
    .reset            (reset),
    .precio_in        (precio_in),
    .precio_valido    (precio_valido),
    .moneda_in        (moneda_in),
    .moneda_in_valid  (moneda_in_valid),
    .cancelar         (cancelar),
    .pago_recibido    (pago_recibido),
    .monto_acumulado  (monto_acumulado),
    .moneda_out       (moneda_out),
    .moneda_out_valid (moneda_out_valid),
    .moneda_out_ack   (moneda_out_ack),
    .es_devolucion    (es_devolucion),
    .moneda_rechazada (moneda_rechazada),
    .precio_invalido  (precio_invalido),
    .ocupado          (ocupado)
  );

  always #5 clk = ~clk;

  // Outputs are observed 1 time unit after each rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic iniciar_cobro(input logic [3:0] codigo);
    precio_valido = 1'b0;
    tick();
    precio_in     = codigo;
    precio_valido = 1'b1;
    tick();
  endtask

  task automatic insertar(input logic [1:0] m);
    moneda_in       = m;
    moneda_in_valid = 1'b1;
    tick();
    moneda_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; precio_in = 4'd0; precio_valido = 1'b0; moneda_in = 2'd0;
    moneda_in_valid = 1'b0; cancelar = 1'b0; moneda_out_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    compared++;
    if ({pago_recibido, monto_acumulado, moneda_out, moneda_out_valid, es_devolucion,
         moneda_rechazada, precio_invalido, ocupado} !== 15'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %0h expected 0", {pago_recibido, monto_acumulado,
               moneda_out, moneda_out_valid, es_devolucion, moneda_rechazada, precio_invalido, ocupado});
    end
  endtask

  task automatic test_pago_exacto();
    iniciar_cobro(4'b0001);
    compared++;
    if ({ocupado, monto_acumulado} !== {1'b1, 7'd0}) begin
      mismatched++; $display("[TB] FAIL exacto_cobrando: got %0b/%0d expected 1/0", ocupado, monto_acumulado);
    end
    insertar(2'b10);
    compared++;
    if ({pago_recibido, moneda_out_valid} !== 2'b10) begin
      mismatched++; $display("[TB] FAIL exacto_pago: got %0b%0b expected 10", pago_recibido, moneda_out_valid);
    end
    tick();
    compared++;
    if ({pago_recibido, moneda_out_valid, ocupado} !== 3'b000) begin
      mismatched++; $display("[TB] FAIL exacto_fin: got %0b%0b%0b expected 000", pago_recibido, moneda_out_valid, ocupado);
    end
  endtask

  task automatic test_vuelto();
    logic [1:0] esperado [3] = '{2'b01, 2'b01, 2'b00};
    iniciar_cobro(4'b0100);
    insertar(2'b11);
    compared++;
    if (pago_recibido !== 1'b1) begin
      mismatched++; $display("[TB] FAIL vuelto_pago: got %0b expected 1", pago_recibido);
    end
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      compared++;
      if ({moneda_out_valid, moneda_out, es_devolucion} !== {1'b1, esperado[i], 1'b0}) begin
        mismatched++; $display("[TB] FAIL vuelto_moneda%0d: got v=%0b m=%0b d=%0b expected v=1 m=%0b d=0",
                               i, moneda_out_valid, moneda_out, es_devolucion, esperado[i]);
      end
      if (i == 0) begin
        for (int k = 0; k < 3; k++) begin
          tick();
          compared++;
          if ({moneda_out_valid, moneda_out} !== {1'b1, esperado[0]}) begin
            mismatched++; $display("[TB] FAIL vuelto_estable%0d: got v=%0b m=%0b expected v=1 m=%0b",
                                   k, moneda_out_valid, moneda_out, esperado[0]);
          end
        end
      end
      moneda_out_ack = 1'b1;
      tick();
      moneda_out_ack = 1'b0;
      compared++;
      if (moneda_out_valid !== 1'b0) begin
        mismatched++; $display("[TB] FAIL vuelto_valid_cae%0d: got %0b expected 0", i, moneda_out_valid);
      end
      tick();
    end
    compared++;
    if ({ocupado, moneda_out_valid, es_devolucion} !== 3'b000) begin
      mismatched++; $display("[TB] FAIL vuelto_fin: got %0b%0b%0b expected 000", ocupado, moneda_out_valid, es_devolucion);
    end
  endtask

  task automatic test_acumulado();
    logic [1:0] monedas [4] = '{2'b11, 2'b11, 2'b01, 2'b01};
    logic [6:0] sumas   [4] = '{7'd20, 7'd40, 7'd42, 7'd44};
    iniciar_cobro(4'b1000);
    for (int i = 0; i < 4; i++) begin
      insertar(monedas[i]);
      compared++;
      if ({pago_recibido, monto_acumulado} !== {1'b0, sumas[i]}) begin
        mismatched++; $display("[TB] FAIL acum_%0d: got pago=%0b monto=%0d expected pago=0 monto=%0d",
                               i, pago_recibido, monto_acumulado, sumas[i]);
      end
    end
    insertar(2'b00);
    compared++;
    if ({pago_recibido, monto_acumulado} !== {1'b1, 7'd0}) begin
      mismatched++; $display("[TB] FAIL acum_pago: got pago=%0b monto=%0d expected 1/0", pago_recibido, monto_acumulado);
    end
    tick();
    compared++;
    if ({ocupado, moneda_out_valid, pago_recibido} !== 3'b000) begin
      mismatched++; $display("[TB] FAIL acum_sin_vuelto: got %0b%0b%0b expected 000", ocupado, moneda_out_valid, pago_recibido);
    end
  endtask

  task automatic test_cancelar();
    iniciar_cobro(4'b0011);
    insertar(2'b10);
    compared++;
    if (monto_acumulado !== 7'd10) begin
      mismatched++; $display("[TB] FAIL cancel_acum: got %0d expected 10", monto_acumulado);
    end
    cancelar = 1'b1; tick(); cancelar = 1'b0;
    compared++;
    if ({pago_recibido, es_devolucion, moneda_out_valid, monto_acumulado} !== {3'b010, 7'd0}) begin
      mismatched++; $display("[TB] FAIL cancel_entrada: got p=%0b d=%0b v=%0b monto=%0d expected 0/1/0/0",
                             pago_recibido, es_devolucion, moneda_out_valid, monto_acumulado);
    end
    tick();
    compared++;
    if ({moneda_out_valid, moneda_out, es_devolucion} !== 4'b1101) begin
      mismatched++; $display("[TB] FAIL cancel_devuelve500: got v=%0b m=%0b d=%0b expected 1/10/1",
                             moneda_out_valid, moneda_out, es_devolucion);
    end
    moneda_out_ack = 1'b1; tick(); moneda_out_ack = 1'b0; tick();
    compared++;
    if ({ocupado, es_devolucion, moneda_out_valid} !== 3'b000) begin
      mismatched++; $display("[TB] FAIL cancel_fin: got %0b%0b%0b expected 000", ocupado, es_devolucion, moneda_out_valid);
    end

    // A 100 coin arriving together with cancel joins the earlier 500 in the refund.
    iniciar_cobro(4'b0011);
    insertar(2'b10);
    moneda_in = 2'b01; moneda_in_valid = 1'b1; cancelar = 1'b1;
    tick();
    moneda_in_valid = 1'b0; cancelar = 1'b0;
    tick();
    compared++;
    if ({moneda_out_valid, moneda_out, es_devolucion} !== 4'b1101) begin
      mismatched++; $display("[TB] FAIL cancel_mixto500: got v=%0b m=%0b d=%0b expected 1/10/1",
                             moneda_out_valid, moneda_out, es_devolucion);
    end
    moneda_out_ack = 1'b1; tick(); moneda_out_ack = 1'b0; tick();
    compared++;
    if ({moneda_out_valid, moneda_out, es_devolucion} !== 4'b1011) begin
      mismatched++; $display("[TB] FAIL cancel_mixto100: got v=%0b m=%0b d=%0b expected 1/01/1",
                             moneda_out_valid, moneda_out, es_devolucion);
    end
    moneda_out_ack = 1'b1; tick(); moneda_out_ack = 1'b0; tick();
    compared++;
    if (ocupado !== 1'b0) begin
      mismatched++; $display("[TB] FAIL cancel_mixto_fin: got %0b expected 0", ocupado);
    end

    // Cancel with nothing inserted returns straight to idle.
    iniciar_cobro(4'b0001);
    cancelar = 1'b1; tick(); cancelar = 1'b0;
    compared++;
    if ({ocupado, es_devolucion, moneda_out_valid} !== 3'b000) begin
      mismatched++; $display("[TB] FAIL cancel_vacio: got %0b%0b%0b expected 000", ocupado, es_devolucion, moneda_out_valid);
    end
  endtask

  task automatic test_precio_cae();
    iniciar_cobro(4'b0010);
    insertar(2'b01);
    insertar(2'b00);
    compared++;
    if (monto_acumulado !== 7'd3) begin
      mismatched++; $display("[TB] FAIL cae_acum: got %0d expected 3", monto_acumulado);
    end
    precio_valido = 1'b0;
    tick();
    compared++;
    if ({es_devolucion, ocupado, pago_recibido} !== 3'b110) begin
      mismatched++; $display("[TB] FAIL cae_entrada: got %0b%0b%0b expected 110", es_devolucion, ocupado, pago_recibido);
    end
    tick();
    compared++;
    if ({moneda_out_valid, moneda_out} !== 3'b101) begin
      mismatched++; $display("[TB] FAIL cae_100: got v=%0b m=%0b expected 1/01", moneda_out_valid, moneda_out);
    end
    moneda_in = 2'b00; moneda_in_valid = 1'b1;
    tick();
    moneda_in_valid = 1'b0;
    compared++;
    if ({moneda_rechazada, moneda_out_valid, moneda_out} !== 4'b1101) begin
      mismatched++; $display("[TB] FAIL cae_rechazo: got r=%0b v=%0b m=%0b expected 1/1/01",
                             moneda_rechazada, moneda_out_valid, moneda_out);
    end
    moneda_out_ack = 1'b1; tick(); moneda_out_ack = 1'b0;
    compared++;
    if ({moneda_rechazada, moneda_out_valid} !== 2'b00) begin
      mismatched++; $display("[TB] FAIL cae_rechazo_pulso: got r=%0b v=%0b expected 0/0", moneda_rechazada, moneda_out_valid);
    end
    tick();
    compared++;
    if ({moneda_out_valid, moneda_out, es_devolucion} !== 4'b1001) begin
      mismatched++; $display("[TB] FAIL cae_50: got v=%0b m=%0b d=%0b expected 1/00/1", moneda_out_valid, moneda_out, es_devolucion);
    end
    moneda_out_ack = 1'b1; tick(); moneda_out_ack = 1'b0; tick();
    compared++;
    if ({ocupado, es_devolucion} !== 2'b00) begin
      mismatched++; $display("[TB] FAIL cae_fin: got %0b%0b expected 00", ocupado, es_devolucion);
    end
  endtask

  task automatic test_invalido_reset();
    precio_valido = 1'b0;
    tick();
    precio_in = 4'b0000; precio_valido = 1'b1;
    tick();
    compared++;
    if ({precio_invalido, ocupado} !== 2'b10) begin
      mismatched++; $display("[TB] FAIL invalido_pulso: got %0b%0b expected 10", precio_invalido, ocupado);
    end
    tick();
    compared++;
    if ({precio_invalido, ocupado} !== 2'b00) begin
      mismatched++; $display("[TB] FAIL invalido_fin: got %0b%0b expected 00", precio_invalido, ocupado);
    end
    iniciar_cobro(4'b0001);
    insertar(2'b11);
    tick(); tick();
    compared++;
    if ({moneda_out_valid, moneda_out, es_devolucion} !== 4'b1100) begin
      mismatched++; $display("[TB] FAIL reset_previo: got v=%0b m=%0b d=%0b expected 1/10/0",
                             moneda_out_valid, moneda_out, es_devolucion);
    end
    reset = 1'b1;
    tick();
    compared++;
    if ({pago_recibido, monto_acumulado, moneda_out, moneda_out_valid, es_devolucion,
         moneda_rechazada, precio_invalido, ocupado} !== 15'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_entrega: got %0h expected 0", {pago_recibido, monto_acumulado,
               moneda_out, moneda_out_valid, es_devolucion, moneda_rechazada, precio_invalido, ocupado});
    end
    reset = 1'b0; precio_valido = 1'b0;
    tick();
    compared++;
    if ({ocupado, moneda_out_valid} !== 2'b00) begin
      mismatched++; $display("[TB] FAIL reset_abandono: got %0b%0b expected 00", ocupado, moneda_out_valid);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_pago_exacto();
    test_vuelto();
    test_acumulado();
    test_cancelar();
    test_precio_cae();
    test_invalido_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
